seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 157 +++++++++++++++
 tb/tb_seq_div.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// Result is packed as {remainder, quotient} and held until the next completion.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH:0]       a_reg;
    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     d_reg;
    logic                 sign_q_reg;
    logic                 sign_r_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 dbz_reg;
    logic [2*WIDTH-1:0]   z_reg;

    logic                 accept;
    logic                 divisor_zero;
    logic                 dvd_neg;
    logic                 dvs_neg;
    logic [WIDTH-1:0]     dvd_mag;
    logic [WIDTH-1:0]     dvs_mag;
    logic [WIDTH+1:0]     a_shift;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;

    assign accept       = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign divisor_zero = (divisor == '0);
    assign dvd_neg      = signed_op & dividend[WIDTH-1];
    assign dvs_neg      = signed_op & divisor[WIDTH-1];
    assign dvd_mag      = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag      = dvs_neg ? (~divisor + 1'b1) : divisor;

    // One restoring step: shift {A,Q} left, trial-subtract; the top bit of
    // trial is the borrow, set exactly when the subtraction went negative.
    assign a_shift = {a_reg, q_reg[WIDTH-1]};
    assign trial   = a_shift - {2'b00, d_reg};

    assign q_fix = sign_q_reg ? (~q_reg + 1'b1) : q_reg;
    assign r_fix = sign_r_reg ? (~a_reg[WIDTH-1:0] + 1'b1) : a_reg[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = divisor_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN, FIX: busy = 1'b1;
            DONE:     done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_reg      <= '0;
            q_reg      <= '0;
            d_reg      <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            cnt_reg    <= '0;
            dbz_reg    <= 1'b0;
            z_reg      <= '0;
        end else begin
            if (accept) begin
                if (divisor_zero) begin
                    z_reg   <= {dividend, {WIDTH{1'b1}}};
                    dbz_reg <= 1'b1;
                end else begin
                    a_reg      <= '0;
                    q_reg      <= dvd_mag;
                    d_reg      <= dvs_mag;
                    sign_q_reg <= dvd_neg ^ dvs_neg;
                    sign_r_reg <= dvd_neg;
                    cnt_reg    <= CW'(WIDTH - 1);
                    dbz_reg    <= 1'b0;
                end
            end else if (state_reg == RUN) begin
                if (trial[WIDTH+1]) begin
                    a_reg <= a_shift[WIDTH:0];
                    q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                end else begin
                    a_reg <= trial[WIDTH:0];
                    q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                end
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end else if (state_reg == FIX) begin
                z_reg <= {r_fix, q_fix};
            end
        end
    end

    assign Z           = z_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div.sv
// Randomized and directed checks of seq_div (WIDTH=32) against a plain
// arithmetic reference of truncating signed/unsigned division.
module tb_seq_div;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic            start = 1'b0;
    logic            signed_op = 1'b0;
    logic [W-1:0]    dividend = '0;
    logic [W-1:0]    divisor = '0;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [2*W-1:0]  Z;

    int tests = 0;
    int fails = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Z           (Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} of truncating division, plus zero flag.
    function automatic logic [63:0] model(input logic s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, output logic dbz);
        longint sa, sb, lq, lr;
        logic [W-1:0] uq, ur;
        dbz = 1'b0;
        if (b == 0) begin
            dbz = 1'b1;
            return {a, 32'hFFFF_FFFF};
        end
        if (!s) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        return {lr[31:0], lq[31:0]};
    endfunction

    // Issue one division; inj >= 0 pulses a competing start (other operands)
    // so that it is sampled inj+1 edges after acceptance.
    task automatic do_div(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj,
                          output int lat, output int busy_cnt);
        logic [63:0] exp_z;
        logic        exp_dbz;
        exp_z = model(s, a, b, exp_dbz);
        @(negedge clk);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
        lat = 0; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == inj) begin
                start = 1'b1; dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        if (lat >= 100) chk({tag, "_timeout"}, 64'(lat), 64'd0);
        chk({tag, "_z"}, Z, exp_z);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        $display("[TB] %s s=%0d %h/%h -> Z=%h dbz=%0d lat=%0d", tag, s, a, b, Z, div_by_zero, lat);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, Z, exp_z);
    endtask

    initial begin
        int lat, bc, quiet;
        logic [W-1:0] ra, rb;
        logic rs;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_z", Z, 64'd0);
        @(negedge clk); clr = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, -1, lat, bc);
        chk("u100_7_const", Z, 64'h00000002_0000000E);
        chk("u100_7_lat", 64'(lat), 64'd33);
        chk("u100_7_busy", 64'(bc), 64'd33);

        do_div("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2, -1, lat, bc);
        chk("sm7_2_const", Z, 64'hFFFFFFFF_FFFFFFFD);
        do_div("um7_2", 1'b0, 32'hFFFFFFF9, 32'd2, -1, lat, bc);
        chk("um7_2_const", Z, 64'h00000001_7FFFFFFC);

        do_div("min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, lat, bc);
        chk("min_m1_const", Z, 64'h00000000_80000000);
        chk("min_m1_dbz", 64'(div_by_zero), 64'd0);

        do_div("d55_0", 1'b0, 32'd55, 32'd0, -1, lat, bc);
        chk("d55_0_const", Z, 64'h00000037_FFFFFFFF);
        chk("d55_0_lat", 64'(lat), 64'd0);
        do_div("d9_3", 1'b0, 32'd9, 32'd3, -1, lat, bc);
        chk("d9_3_const", Z, 64'h00000000_00000003);

        do_div("ignore_start", 1'b0, 32'd12345, 32'd67, 9, lat, bc);
        chk("ignore_lat", 64'(lat), 64'd33);

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd77; divisor = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (15) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_dbz", 64'(div_by_zero), 64'd0);
        chk("clr_z", Z, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); clr = 1'b0;
        quiet = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) quiet++;
        end
        chk("clr_no_done", 64'(quiet), 64'd0);
        do_div("after_clr", 1'b0, 32'd100, 32'd7, -1, lat, bc);
        chk("after_clr_lat", 64'(lat), 64'd33);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
                3: rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            if (i % 7 == 0) ra = 32'h80000000;
            do_div($sformatf("rnd%0d", i), rs, ra, rb, -1, lat, bc);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), (rb == 0) ? 64'd0 : 64'd33);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
